// File: rtl/instruction_decoder_pipe.sv
// Opcode decoder with one registered output stage (1-cycle latency, valid/ready, holds while stalled).
// Define ID_HAZARD_DETECT_EN to insert a NOP bubble when an instruction reads the register written by the previous word.
module instruction_decoder_pipe #(
  parameter int RA_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7+3*RA_W-1:0]   instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RA_W-1:0]       DA,
  output logic [RA_W-1:0]       AA,
  output logic [RA_W-1:0]       BA,
  output logic                  MB,
  output logic                  MD,
  output logic                  RW,
  output logic                  MW,
  output logic                  PL,
  output logic                  JB,
  output logic                  BC,
  output logic [3:0]            FS,
  output logic                  bubble,
  output logic [CNT_W-1:0]      retired
);

  localparam int IW = 7 + 3*RA_W;

  logic [6:0]      op;
  logic [RA_W-1:0] d_da, d_aa, d_ba;
  logic            d_mb, d_md, d_rw, d_mw, d_pl, d_jb, d_bc;
  logic [3:0]      d_fs;
  logic            stage_free, accept, hazard, bubble_q;

  assign op   = instr[IW-1 -: 7];
  assign d_da = instr[3*RA_W-1 -: RA_W];
  assign d_aa = instr[2*RA_W-1 -: RA_W];
  assign d_ba = instr[RA_W-1:0];

  assign d_mb = op[6];
  assign d_md = op[4];
  assign d_jb = op[4];
  assign d_bc = op[0];
  assign d_rw = ~op[5];
  assign d_mw = ~op[6] & op[5];
  assign d_pl = op[6] & op[5];
  assign d_fs = {op[3:1], op[0] & ~d_pl};

  assign stage_free = ~out_valid | out_ready;
  assign in_ready   = rst_n & stage_free & ~hazard;
  assign accept     = in_valid & in_ready;

`ifdef ID_HAZARD_DETECT_EN
  localparam bit HAZ_EN = 1'b1;

  // last_wr/last_da describe the most recently loaded word, but only while it can still collide
  logic            last_wr;
  logic [RA_W-1:0] last_da;

  assign hazard = in_valid & stage_free & last_wr &
                  ((last_da == d_aa) | ((last_da == d_ba) & ~d_mb));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_wr <= 1'b0;
      last_da <= '0;
    end else if (accept) begin
      last_wr <= d_rw;
      last_da <= d_da;
    end else if (hazard) begin
      last_wr <= 1'b0;
    end else if (!out_valid) begin
      last_wr <= 1'b0;
    end
  end
`else
  localparam bit HAZ_EN = 1'b0;

  assign hazard = 1'b0;
`endif

  assign bubble = HAZ_EN ? bubble_q : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bubble_q  <= 1'b0;
      retired   <= '0;
      DA        <= '0;
      AA        <= '0;
      BA        <= '0;
      MB        <= 1'b0;
      MD        <= 1'b0;
      RW        <= 1'b0;
      MW        <= 1'b0;
      PL        <= 1'b0;
      JB        <= 1'b0;
      BC        <= 1'b0;
      FS        <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        bubble_q  <= 1'b0;
        DA        <= d_da;
        AA        <= d_aa;
        BA        <= d_ba;
        MB        <= d_mb;
        MD        <= d_md;
        RW        <= d_rw;
        MW        <= d_mw;
        PL        <= d_pl;
        JB        <= d_jb;
        BC        <= d_bc;
        FS        <= d_fs;
      end else if (hazard) begin
        // the instruction stays on the input; a NOP goes out in its place
        out_valid <= 1'b1;
        bubble_q  <= 1'b1;
        DA        <= '0;
        AA        <= '0;
        BA        <= '0;
        MB        <= 1'b0;
        MD        <= 1'b0;
        RW        <= 1'b0;
        MW        <= 1'b0;
        PL        <= 1'b0;
        JB        <= 1'b0;
        BC        <= 1'b0;
        FS        <= '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        bubble_q  <= 1'b0;
      end

      if (out_valid && out_ready && !bubble)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instruction_decoder_pipe.sv
// Scoreboard bench for instruction_decoder_pipe (RA_W=3, CNT_W=4 so the retired counter wraps quickly).
module tb_instruction_decoder_pipe;
  localparam int RA_W  = 3;
  localparam int CNT_W = 4;
  localparam int IW    = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IW-1:0]   instr = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [RA_W-1:0] DA, AA, BA;
  logic            MB, MD, RW, MW, PL, JB, BC;
  logic [3:0]      FS;
  logic            bubble;
  logic [CNT_W-1:0] retired;

  instruction_decoder_pipe #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .DA(DA), .AA(AA), .BA(BA),
    .MB(MB), .MD(MD), .RW(RW), .MW(MW), .PL(PL), .JB(JB), .BC(BC), .FS(FS),
    .bubble(bubble), .retired(retired)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          bub_cnt = 0;
  logic [3:0]  ret_exp = '0;
  bit          rand_rdy = 1'b0;
  logic [19:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] exp_word(input logic [15:0] ins);
    logic [6:0] op;
    logic       pl;
    op = ins[15:9];
    pl = op[6] & op[5];
    return {ins[8:0], op[6], op[4], ~op[5], ~op[6] & op[5], pl, op[4], op[0],
            op[3:1], op[0] & ~pl};
  endfunction

  function automatic logic [19:0] obs();
    return {DA, AA, BA, MB, MD, RW, MW, PL, JB, BC, FS};
  endfunction

  // Output monitor: samples 2 time units after the falling edge
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      sb.delete();
      ret_exp = '0;
      check("rst_in_ready", in_ready, 0);
    end else begin
      check("retired", retired, ret_exp);
      if (out_valid && out_ready) begin
        if (bubble) begin
          bub_cnt++;
          check("bubble_nop", obs(), 0);
        end else if (sb.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          check("word", obs(), sb.pop_front());
          ret_exp++;
        end
      end
    end
  end

  task automatic send(input logic [IW-1:0] ins);
    int n = 0;
    @(negedge clk);
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    instr = ins;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    if (in_ready) begin
      sb.push_back(exp_word(ins));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end else begin
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input int cycles);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_bubble", bubble, 0);
    check("rst_retired", retired, 0);
    check("rst_fields", obs(), 0);
    check("rst_ready", in_ready, 0);
    rst_n = 1'b1;

    // ALU-type opcode 0x05
    out_ready = 1'b1;
    send(16'h0A1A);
    check("a_valid", out_valid, 1);
    check("a_fs", FS, 4'h5);
    check("a_rw", RW, 1);
    check("a_mw", MW, 0);
    check("a_pl", PL, 0);
    check("a_aa", AA, 3);
    check("a_ba", BA, 2);
    @(posedge clk);
    #1;
    check("a_retired", retired, 1);

    // PL opcode 0x61
    send(16'hC2C8);
    check("b_fs", FS, 4'h0);
    check("b_jb", JB, 0);
    check("b_bc", BC, 1);
    check("b_rw", RW, 0);
    check("b_mw", MW, 0);
    check("b_pl", PL, 1);
    drain(2);

    // stall for 5 cycles
    @(negedge clk);
    out_ready = 1'b0;
    send({7'h12, 3'd4, 3'd5, 3'd6});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_word", obs(), exp_word({7'h12, 3'd4, 3'd5, 3'd6}));
      check("hold_retired", retired, 2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_retired", retired, 3);
    check("release_empty", out_valid, 0);

    // reset while a word is held
    @(negedge clk);
    out_ready = 1'b0;
    send({7'h03, 3'd7, 3'd6, 3'd5});
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_retired", retired, 0);
    check("midrst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("midrst_gone", out_valid, 0);
    end

    // write R1 then read R1 on AA
    bub_cnt = 0;
    send({7'h05, 3'd1, 3'd2, 3'd3});
    send({7'h05, 3'd4, 3'd1, 3'd5});
    drain(4);
`ifdef ID_HAZARD_DETECT_EN
    check("raw_bubbles", bub_cnt, 1);
`else
    check("raw_bubbles", bub_cnt, 0);
`endif
    check("raw_retired", retired, 2);

    // 17 words into a 4-bit counter
    pulse_reset();
    for (int i = 0; i < 17; i++) send(16'($urandom));
    drain(3);
    check("wrap_retired", retired, 1);

    // random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) send(16'($urandom));
    rand_rdy = 1'b0;
    drain(4);
    check("sb_drained", sb.size(), 0);
    check("drained_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_decoder_pipe.md
INSTRUCTION_DECODER_PIPE -- requirements
Module: instruction_decoder_pipe

Interface
REQ-001 SHALL have parameter RA_W, default 3: register address width; instruction width IW = 7 + 3*RA_W.
REQ-002 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 SHALL have port clk  input  1  the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  instr holds a valid instruction.
REQ-006 SHALL have port in_ready  output  1  the decoder accepts instr this cycle.
REQ-007 SHALL have port instr  input  IW  machine instruction: opcode op = instr[IW-1:IW-7], then DA, AA, BA fields of RA_W bits each, from high to low.
REQ-008 SHALL have port out_valid  output  1  the decoded control word is valid.
REQ-009 SHALL have port out_ready  input  1  the downstream datapath consumes the control word.
REQ-010 SHALL have ports DA, AA, BA  output  RA_W each  registered register addresses.
REQ-011 SHALL have ports MB, MD, RW, MW, PL, JB, BC  output  1 each  registered control bits.
REQ-012 SHALL have port FS  output  4  registered function select.
REQ-013 SHALL have port bubble  output  1  the current control word is an inserted NOP.
REQ-014 SHALL have port retired  output  CNT_W  count of non-bubble control words consumed.

Function
REQ-015 SHALL decode the opcode as follows: MB=op[6], MD=op[4], JB=op[4], BC=op[0], RW=~op[5], MW=~op[6]&op[5], PL=op[6]&op[5], FS={op[3:1], op[0]&~PL}.
REQ-016 SHALL register all decoded outputs in one output stage, giving a latency of exactly 1 cycle from acceptance to out_valid.
REQ-017 SHALL drive in_ready = (~out_valid | out_ready) & ~hazard, combinationally.
REQ-018 SHALL accept an instruction when in_valid & in_ready, and load its decoded word with out_valid=1 and bubble=0.
REQ-019 SHALL hold every output stable while out_valid & ~out_ready.
REQ-020 SHALL clear out_valid when out_ready is high and no new word or bubble is loaded.
REQ-021 SHALL, on simultaneous consume and accept, replace the word with no idle cycle, sustaining one word per clock.
REQ-022 SHALL increment retired by 1 for each cycle with out_valid & out_ready & ~bubble, and SHALL wrap from all-ones to 0.
REQ-023 SHALL not modify any register or output while in_valid is low and the output stage is empty, apart from the hazard-tracking register of REQ-030.
REQ-024 SHALL never drop, duplicate or reorder instructions.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, clear out_valid, bubble, retired, DA, AA, BA, FS, MB, MD, RW, MW, PL, JB and BC to 0, and clear the hazard-tracking register.
REQ-026 SHALL discard any word held in the output stage when reset is asserted mid-operation, and SHALL never present it again.
REQ-027 SHALL drive in_ready=0 in any cycle with rst_n=0.

Configuration
REQ-028 SHALL compile in hazard detection when macro ID_HAZARD_DETECT_EN is defined; without the macro, hazard SHALL be tied to 0 and bubble SHALL be constantly 0.
REQ-029 SHALL, with the macro defined, assert hazard when all of the following hold:
- in_valid=1 and the output stage is free;
- the last issued word had RW=1;
- its DA equals the incoming AA, or equals the incoming BA while incoming MB=0.
REQ-030 SHALL, with the macro defined, track the last issued word as follows:
- it is the most recent word loaded into the output stage;
- it is cleared when that word is a bubble;
- it is cleared when the output stage has been empty for one full cycle.
REQ-031 SHALL, on hazard, load a NOP instead of the instruction:
- RW=MW=PL=0, FS=0, all other outputs 0;
- bubble=1, out_valid=1;
- the instruction is left waiting, with in_ready low.
The next cycle SHALL then accept the instruction, because a bubble clears the tracking.

Verification
REQ-032 SHALL cover: RA_W=3, instr=16'h0A1A (op=7'h05, DA=0, AA=3, BA=2) with in_valid=1 and out_ready=1 -> next cycle out_valid=1, RW=1, MW=0, PL=0, FS=4'h5, AA=3, BA=2, and retired=1 one cycle after.
REQ-033 SHALL cover: instr=16'hC2C8 (op=7'h61, PL=1) -> FS=4'h0, JB=0, BC=1, RW=0, MW=0.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles with a word loaded -> outputs frozen, in_ready=0 and retired unchanged; out_ready=1 then releases the word, with retired incrementing by exactly 1.
REQ-035 SHALL cover: with ID_HAZARD_DETECT_EN defined, a back-to-back write to R1 followed by a read of R1 on AA -> one bubble=1 word between the two, and retired=2 after draining; without the macro the same stimulus -> no bubble.
REQ-036 SHALL cover: rst_n=0 for one cycle while out_valid=1 -> out_valid=0 and retired=0 the next cycle, with the held word never seen afterwards.
REQ-037 SHALL cover: CNT_W=4 with 17 consumed words -> retired=1 (wrap-around).
